// File: rtl/alu_exec_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_mc
// Purpose  : Multi-cycle ALU execute stage. Single-cycle logic/arith/shift ops
//            and an iterative shift-add MUL that stalls the pipe via in_ready.
//            Optional macro MUL_EARLY_EXIT_EN ends MUL once the multiplier drains.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_mc #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              busy
);

    localparam int SHAMT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_iters = CNT_W'(DATA_W);

    localparam logic [3:0] c_op_and = 4'd0;
    localparam logic [3:0] c_op_or  = 4'd1;
    localparam logic [3:0] c_op_add = 4'd2;
    localparam logic [3:0] c_op_sll = 4'd3;
    localparam logic [3:0] c_op_srl = 4'd4;
    localparam logic [3:0] c_op_sub = 4'd6;
    localparam logic [3:0] c_op_slt = 4'd7;
    localparam logic [3:0] c_op_mul = 4'd8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_accept;
    logic [SHAMT_W-1:0]  w_shamt;
    logic [DATA_W-1:0]   w_alu;
    logic [DATA_W-1:0]   w_acc_next;
    logic [DATA_W-1:0]   w_mcand_next;
    logic [DATA_W-1:0]   w_mplier_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_mul_done;

    assign in_ready = (r_state == IDLE);
    assign busy     = ~in_ready;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_shamt  = op_b[SHAMT_W-1:0];

    always_comb begin
        w_alu = '0;
        case (alu_control)
            c_op_and: w_alu = op_a & op_b;
            c_op_or:  w_alu = op_a | op_b;
            c_op_add: w_alu = op_a + op_b;
            c_op_sll: w_alu = op_a << w_shamt;
            c_op_srl: w_alu = op_a >> w_shamt;
            c_op_sub: w_alu = op_a - op_b;
            c_op_slt: w_alu = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default:  w_alu = '0;
        endcase
    end

    // One shift-add step; the completing edge writes the post-step accumulator.
    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mcand_next  = r_mcand << 1;
    assign w_mplier_next = r_mplier >> 1;
    assign w_cnt_next    = r_cnt + 1'b1;

`ifdef MUL_EARLY_EXIT_EN
    assign w_mul_done = (w_cnt_next == c_iters) || (w_mplier_next == '0);
`else
    assign w_mul_done = (w_cnt_next == c_iters);
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= IDLE;
            result    <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            if (alu_control == c_op_mul) begin
                                r_mcand  <= op_a;
                                r_mplier <= op_b;
                                r_acc    <= '0;
                                r_cnt    <= '0;
                                r_state  <= MUL_RUN;
                            end else begin
                                result    <= w_alu;
                                zero      <= (w_alu == '0);
                                out_valid <= 1'b1;
                            end
                        end
                    end
                    MUL_RUN: begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= w_mcand_next;
                        r_mplier <= w_mplier_next;
                        r_cnt    <= w_cnt_next;
                        if (w_mul_done) begin
                            result    <= w_acc_next;
                            zero      <= (w_acc_next == '0);
                            out_valid <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_mc
// Purpose  : Self-checking bench for alu_exec_mc (scoreboard queue of results).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_mc;

    localparam int DW = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic [3:0]    alu_control = 4'd0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] result;
    logic          zero;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Entries are {zero, result}
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] last_res = '0;
    logic          last_zero = 1'b1;

    always #5 clk = ~clk;

    alu_exec_mc #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_control(alu_control),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .result     (result),
        .zero       (zero),
        .busy       (busy)
    );

    function automatic logic [DW-1:0] model(input logic [3:0] ctl, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic [4:0]    sh;
        sh = b[4:0];
        case (ctl)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a + b;
            4'd3: r = a << sh;
            4'd4: r = a >> sh;
            4'd6: r = a - b;
            4'd7: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd8: r = a * b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int mul_latency(input logic [DW-1:0] b);
        int lat;
`ifdef MUL_EARLY_EXIT_EN
        lat = 1;
        for (int i = 0; i < DW; i++) if (b[i]) lat = i + 1;
`else
        lat = DW;
`endif
        return lat;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = ctl;
        op_a        = a;
        op_b        = b;
        r = model(ctl, a, b);
        exp_q.push_back({(r == '0), r});
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            result !== '0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: ready=%b busy=%b ov=%b res=%h zero=%b, want 1 0 0 0 1",
                     in_ready, busy, out_valid, result, zero);
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [DW:0] e;
        drive(4'd2, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL add_valid: ov=%b q=%0d, want ov=1", out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            last_res = e[DW-1:0]; last_zero = e[DW];
            n_checks++;
            if (result !== e[DW-1:0] || zero !== e[DW] || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL add_result: res=%h zero=%b ready=%b, want %h %b 1",
                         result, zero, in_ready, e[DW-1:0], e[DW]);
            end
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_pulse: ov=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]    ctl[14];
        logic [DW-1:0] av[14];
        logic [DW-1:0] bv[14];
        logic [3:0]    codes[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd5, 4'd9, 4'd15};
        logic [DW:0]   e;
        ctl[0] = 4'd6; av[0] = 32'd3;          bv[0] = 32'd5;
        ctl[1] = 4'd7; av[1] = 32'hFFFF_FFFF;  bv[1] = 32'd1;
        ctl[2] = 4'd4; av[2] = 32'h8000_0000;  bv[2] = 32'h21;
        ctl[3] = 4'd5; av[3] = 32'd9;          bv[3] = 32'd4;
        for (int i = 4; i < 14; i++) begin
            ctl[i] = codes[$urandom_range(0, 9)];
            av[i]  = $urandom;
            bv[i]  = $urandom;
        end
        for (int i = 0; i < 14; i++) begin
            drive(ctl[i], av[i], bv[i]);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_valid[%0d]: ov=%b, want 1", i, out_valid);
            end else begin
                e = exp_q.pop_front();
                last_res = e[DW-1:0]; last_zero = e[DW];
                if (result !== e[DW-1:0] || zero !== e[DW]) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d] op=%0d: res=%h zero=%b, want %h %b",
                             i, ctl[i], result, zero, e[DW-1:0], e[DW]);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulse: ov=%b, want 0", out_valid);
        end
    endtask

    task automatic mul_case(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit hold_add);
        int lat, cyc;
        bit done, busy_bad;
        logic [DW:0] e;
        lat = mul_latency(b);
        drive(4'd8, a, b);
        tick();
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_start: busy=%b ready=%b ov=%b, want 1 0 0", busy, in_ready, out_valid);
        end
        if (hold_add) begin
            alu_control = 4'd2; op_a = 32'd1; op_b = 32'd1;
        end else begin
            in_valid = 1'b0;
        end
        cyc = 0; done = 1'b0; busy_bad = 1'b0;
        while (!done && cyc < DW + 8) begin
            tick();
            cyc++;
            if (out_valid === 1'b1) done = 1'b1;
            else if (busy !== 1'b1) busy_bad = 1'b1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!done || cyc != lat) begin
            n_fail++;
            $display("FAIL mul_latency a=%h b=%h: done=%b cycles=%0d, want %0d", a, b, done, cyc, lat);
        end
        n_checks++;
        if (busy_bad || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_busy: dropped=%b ready=%b busy=%b, want 0 1 0", busy_bad, in_ready, busy);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            last_res = e[DW-1:0]; last_zero = e[DW];
            n_checks++;
            if (result !== e[DW-1:0] || zero !== e[DW]) begin
                n_fail++;
                $display("FAIL mul_result a=%h b=%h: res=%h zero=%b, want %h %b",
                         a, b, result, zero, e[DW-1:0], e[DW]);
            end
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_pulse: ov=%b, want 0", out_valid);
        end
    endtask

    task automatic test_mul();
        mul_case(32'h1234_5678, 32'd0, 1'b0);
        mul_case(32'd6, 32'd3, 1'b0);
        mul_case($urandom, $urandom, 1'b0);
        mul_case(32'hFFFF_FFFD, 32'd5, 1'b0);
        mul_case(32'd6, 32'd7, 1'b1);
    endtask

    task automatic test_flush();
        bit seen;
        drive(4'd8, 32'h1234, 32'hF678_0000);
        void'(exp_q.pop_back());
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        @(negedge clk);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_abort: ready=%b busy=%b ov=%b, want 1 0 0", in_ready, busy, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < DW + 4; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen || result !== last_res || zero !== last_zero) begin
            n_fail++;
            $display("FAIL flush_discard: ov_seen=%b res=%h zero=%b, want 0 %h %b",
                     seen, result, zero, last_res, last_zero);
        end
        drive(4'd2, 32'd2, 32'd3);
        void'(exp_q.pop_back());
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_wins: ov=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || result !== last_res) begin
            n_fail++;
            $display("FAIL flush_wins_hold: ov=%b res=%h, want 0 %h", out_valid, result, last_res);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        logic [DW:0] e;
        drive(4'd8, 32'd9, 32'd9);
        void'(exp_q.pop_back());
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2 arst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            result !== '0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: ready=%b busy=%b ov=%b res=%h zero=%b, want 1 0 0 0 1",
                     in_ready, busy, out_valid, result, zero);
        end
        @(negedge clk);
        arst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < DW + 4; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL async_no_result: ov_seen=%b, want 0", seen);
        end
        drive(4'd2, 32'd1, 32'd1);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL post_reset_add_valid: ov=%b, want 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            if (result !== e[DW-1:0] || zero !== e[DW]) begin
                n_fail++;
                $display("FAIL post_reset_add: res=%h zero=%b, want %h %b",
                         result, zero, e[DW-1:0], e[DW]);
            end
        end
    endtask

    task automatic test_drain();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_flush();
        test_async_reset();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, limit 500000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
